// File: rtl/axil_apb_bridge_mc_if.sv
// AXI4-Lite slave + multi-completer APB master bundle for axil_apb_bridge_mc.
// slave = bridge view, master = interconnect/peripheral view.
interface axil_apb_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0]         awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_W-1:0]         wdata;
  logic [STRB_W-1:0]         wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_W-1:0]         araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  logic [ADDR_W-1:0]         paddr;
  logic [2:0]                pprot;
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [DATA_W-1:0]         pwdata;
  logic [STRB_W-1:0]         pstrb;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready,
    output paddr, pprot, psel, penable,
    output pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready,
    input  paddr, pprot, psel, penable,
    input  pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/axil_apb_bridge_mc.sv
// AXI4-Lite to APB bridge with address decode over NUM_SLV completers,
// read/write round-robin, and PSLVERR / decode / timeout error mapping.
module axil_apb_bridge_mc #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter int                NUM_SLV       = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(32'h4000_0000),
  parameter int                SLV_ADDR_BITS = 12,
  parameter int                TIMEOUT       = 16
) (
  input  logic       clk,
  input  logic       rst,
  axil_apb_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W:0] SPAN =
    (ADDR_W+1)'(NUM_SLV) << SLV_ADDR_BITS;
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((64'd1 << SLV_ADDR_BITS) - 64'd1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] R_OKAY   = 2'b00;
  localparam logic [1:0] R_SLVERR = 2'b10;
  localparam logic [1:0] R_DECERR = 2'b11;

  logic [1:0]         r_state;
  logic               r_wr_first;
  logic               r_write;
  logic [ADDR_W-1:0]  r_paddr;
  logic [2:0]         r_pprot;
  logic [DATA_W-1:0]  r_pwdata;
  logic [STRB_W-1:0]  r_pstrb;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_SLV-1:0] r_psel;
  logic               r_penable;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_resp;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_bvalid;
  logic               r_rvalid;

  logic               w_idle;
  logic               w_wr_cand;
  logic               w_rd_cand;
  logic               w_gnt_wr;
  logic               w_gnt_rd;
  logic [ADDR_W-1:0]  w_addr;
  logic [ADDR_W-1:0]  w_off;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_SLV-1:0] w_sel;
  logic               w_pready;
  logic               w_pslverr;
  logic [DATA_W-1:0]  w_prdata;
  logic               w_resp_hs;
  logic               w_timeout;

  // Readies are gated by rst so nothing is granted on a reset edge.
  assign w_idle    = (r_state == S_IDLE) && !rst;
  assign w_wr_cand = bus.awvalid && bus.wvalid;
  assign w_rd_cand = bus.arvalid;
  assign w_gnt_wr  = w_idle && w_wr_cand &&
                     (!w_rd_cand || r_wr_first);
  assign w_gnt_rd  = w_idle && w_rd_cand &&
                     (!w_wr_cand || !r_wr_first);

  assign w_addr = w_gnt_wr ? bus.awaddr : bus.araddr;
  assign w_off  = w_addr - BASE_ADDR;
  assign w_hit  = (w_addr >= BASE_ADDR) &&
                  ({1'b0, w_off} < SPAN);
  assign w_idx  = IDX_W'(w_off >> SLV_ADDR_BITS);
  assign w_sel  = NUM_SLV'(1) << w_idx;

  assign w_pready  = bus.pready[r_idx];
  assign w_pslverr = bus.pslverr[r_idx];
  assign w_prdata  = bus.prdata[r_idx*DATA_W +: DATA_W];
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));
  assign w_resp_hs = r_write ? bus.bready : bus.rready;

  assign bus.awready = w_gnt_wr;
  assign bus.wready  = w_gnt_wr;
  assign bus.arready = w_gnt_rd;
  assign bus.bresp   = r_resp;
  assign bus.rresp   = r_resp;
  assign bus.bvalid  = r_bvalid;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.paddr   = r_paddr;
  assign bus.pprot   = r_pprot;
  assign bus.psel    = r_psel;
  assign bus.penable = r_penable;
  assign bus.pwrite  = r_write;
  assign bus.pwdata  = r_pwdata;
  assign bus.pstrb   = r_pstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_first <= 1'b1;
      r_write    <= 1'b0;
      r_paddr    <= '0;
      r_pprot    <= '0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_idx      <= '0;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_cnt      <= '0;
      r_resp     <= R_OKAY;
      r_rdata    <= '0;
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_wr || w_gnt_rd) begin
            if (w_wr_cand && w_rd_cand)
              r_wr_first <= !r_wr_first;
            r_write <= w_gnt_wr;
            if (w_hit) begin
              r_paddr  <= w_off & OFF_MASK;
              r_pprot  <= w_gnt_wr ? bus.awprot : bus.arprot;
              r_pwdata <= w_gnt_wr ? bus.wdata : '0;
              r_pstrb  <= w_gnt_wr ? bus.wstrb : '0;
              r_idx    <= w_idx;
              r_psel   <= w_sel;
              r_state  <= S_SETUP;
            end else begin
              // Decode miss answers straight away, APB stays idle.
              r_resp   <= R_DECERR;
              if (w_gnt_rd)
                r_rdata <= '0;
              r_bvalid <= w_gnt_wr;
              r_rvalid <= w_gnt_rd;
              r_state  <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= CNT_W'(1);
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_pready || w_timeout) begin
            if (w_pready) begin
              r_resp <= w_pslverr ? R_SLVERR : R_OKAY;
              if (!r_write)
                r_rdata <= w_prdata;
            end else begin
              r_resp <= R_SLVERR;
              if (!r_write)
                r_rdata <= '0;
            end
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_bvalid  <= r_write;
            r_rvalid  <= !r_write;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/axil_apb_bridge_mc.md
Name: axil_apb_bridge_mc

Overview:
AXI4-Lite slave to APB master bridge that fans one AXI4-Lite port out to NUM_SLV APB completers. Address decode selects the completer. The bridge arbitrates fairly between reads and writes. PREADY wait states, PSLVERR, decode errors and a per-access timeout are all mapped onto AXI BRESP/RRESP. It sits between the AXI4-Lite interconnect and the peripheral APB segment.

Parameters:
DATA_W, 32, AXI/APB data width; must be 32 or 64.
ADDR_W, 32, address width.
NUM_SLV, 4, number of APB completers; 1..16.
BASE_ADDR, 32'h4000_0000, base of the decoded window.
SLV_ADDR_BITS, 12, per-completer region is 2^SLV_ADDR_BITS bytes.
TIMEOUT, 16, maximum ACCESS cycles before forced error; must be at least 2.

Ports:
clk  in  1  single clock for AXI and APB sides.
rst  in  1  synchronous, active-high reset.
awaddr  in  ADDR_W  AXI write address.
awprot  in  3  AXI write protection.
awvalid  in  1  AXI write address valid.
awready  out  1  AXI write address ready.
wdata  in  DATA_W  AXI write data.
wstrb  in  DATA_W/8  AXI write strobes.
wvalid  in  1  AXI write data valid.
wready  out  1  AXI write data ready.
bresp  out  2  AXI write response code.
bvalid  out  1  AXI write response valid.
bready  in  1  AXI write response ready.
araddr  in  ADDR_W  AXI read address.
arprot  in  3  AXI read protection.
arvalid  in  1  AXI read address valid.
arready  out  1  AXI read address ready.
rdata  out  DATA_W  AXI read data.
rresp  out  2  AXI read response code.
rvalid  out  1  AXI read response valid.
rready  in  1  AXI read response ready.
paddr  out  ADDR_W  APB address; offset within the completer region, upper bits zero.
pprot  out  3  APB protection.
psel  out  NUM_SLV  one-hot APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction, 1 = write.
pwdata  out  DATA_W  APB write data.
pstrb  out  DATA_W/8  APB write strobes.
prdata  in  NUM_SLV*DATA_W  per-completer read data; completer i occupies slice i.
pready  in  NUM_SLV  per-completer ready.
pslverr  in  NUM_SLV  per-completer error.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs are 0, including psel, penable, bvalid, rvalid, bresp, rresp and rdata. The arbiter priority flag is set to "write first". Reset asserted mid-transfer abandons the transfer: psel and penable are 0 after that edge, and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE, write candidate: awvalid && wvalid are both high in the same cycle.
- IDLE, read candidate: arvalid.
- Write and read candidates together: grant the side named by the priority flag, then toggle the flag. A single candidate is granted regardless of the flag.
- On grant: pulse awready and wready (or arready) for exactly that cycle, combinationally, while in IDLE. Latch address, prot, data, strb and direction on the same edge.
- Decode: hit when BASE_ADDR <= addr < BASE_ADDR + NUM_SLV*2^SLV_ADDR_BITS. Completer index = (addr - BASE_ADDR) >> SLV_ADDR_BITS.
- Decode miss: go IDLE -> RESP directly with response DECERR (2'b11). No APB activity. For a read, rdata = 0.
- SETUP (one cycle): psel[idx]=1, penable=0, and paddr, pwrite, pwdata, pstrb, pprot stable. For reads, pstrb=0.
- ACCESS: penable=1, with psel and all APB outputs held. A cycle counter starts at 1 on entry.
- ACCESS exit, pready[idx]=1: capture prdata slice idx into rdata. Response = SLVERR (2'b10) if pslverr[idx] is high, otherwise OKAY (2'b00). Go to RESP.
- ACCESS timeout: counter reaches TIMEOUT with pready still low. Response = SLVERR, rdata = 0, go to RESP. pready arriving in the same cycle the counter reaches TIMEOUT wins over the timeout.
- Leaving ACCESS: psel=0 and penable=0 on the edge that leaves ACCESS. pslverr is ignored when pready is low.
- RESP: bvalid (write) or rvalid (read) is high. bresp/rresp and rdata are held stable until bready/rready is sampled high. Then return to IDLE with the valid deasserted on that edge.
- No new grant is given while not in IDLE; awready, wready and arready are 0 outside IDLE.
- Latency with zero wait states: grant at cycle T, SETUP T+1, ACCESS T+2, valid asserted T+3. Back-to-back: the earliest next grant is the cycle after the response handshake.

Test Plan:
- Write of 32'hDEAD_BEEF to 32'h4000_1004, wstrb 4'hF, pready=1 in the first ACCESS cycle. Required: psel=4'b0010, paddr=32'h004, pwrite=1; bvalid at T+3 with bresp=00.
- Read of 32'h4000_3010, completer 3 holds pready low for 3 ACCESS cycles, prdata[3]=32'h1234_5678. Required: ACCESS lasts 4 cycles; rdata=32'h1234_5678, rresp=00.
- Read of 32'h5000_0000 (outside window). Required: no psel ever asserts; rvalid with rresp=11, rdata=0.
- Write to completer 2 with pready stuck at 0, TIMEOUT=16. Required: exactly 16 ACCESS cycles, then psel=0; bresp=10.
- awvalid, wvalid and arvalid held high continuously from reset, with pslverr on completer 0 for the read. Required: grants alternate write, read, write; the read returns rresp=10.
- rst pulsed for one cycle while in ACCESS. Required: psel and penable are 0 on the next cycle; no bvalid or rvalid; the next request completes normally.
